// File: rtl/param_exec_datapath.sv
// Multi-cycle datapath: regfile, A/B/C operand registers, shifter, ALU, flags, writeback mux.
// Optional DATAPATH_BARREL_EN adds cmd_shamt for variable-distance shifts (default: 1-bit shifts).
module param_exec_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int PC_W  = 8,
  localparam int RW   = $clog2(NREGS),
  localparam int SW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [RW-1:0]    cmd_rn,
  input  logic [RW-1:0]    cmd_rm,
  input  logic [RW-1:0]    cmd_rd,
  input  logic [1:0]       cmd_aluop,
  input  logic [1:0]       cmd_shift,
  input  logic             cmd_asel,
  input  logic             cmd_bsel,
  input  logic [WIDTH-1:0] cmd_imm,
`ifdef DATAPATH_BARREL_EN
  input  logic [SW-1:0]    cmd_shamt,
`endif
  input  logic [1:0]       cmd_vsel,
  input  logic             cmd_wb,
  input  logic             cmd_setf,
  input  logic [WIDTH-1:0] mdata,
  input  logic [PC_W-1:0]  pc,
  output logic             done,
  output logic [WIDTH-1:0] c_out,
  output logic             z_flag,
  output logic             n_flag,
  output logic             v_flag
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RDA  = 3'd1;
  localparam logic [2:0] S_RDB  = 3'd2;
  localparam logic [2:0] S_EXE  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;

  typedef struct packed {
    logic [RW-1:0]    rn, rm, rd;
    logic [1:0]       aluop, shift;
    logic             asel, bsel;
    logic [WIDTH-1:0] imm;
`ifdef DATAPATH_BARREL_EN
    logic [SW-1:0]    shamt;
`endif
    logic [1:0]       vsel;
    logic             wb, setf;
  } cmd_t;

  logic [2:0]                  state_q, state_d;
  cmd_t                        cmd_q, cmd_d;
  logic [NREGS-1:0][WIDTH-1:0] rf_q;
  logic [WIDTH-1:0]            a_q, b_q, c_q;
  logic                        z_q, n_q, v_q;
  logic [WIDTH-1:0]            rd_a, rd_b, sh_b, a_op, b_op, alu, wb_data;
  logic [SW-1:0]               shamt;
  logic                        alu_v;

  assign cmd_ready = (state_q == S_IDLE);
  assign done      = (state_q == S_WB);
  assign c_out     = c_q;
  assign z_flag    = z_q;
  assign n_flag    = n_q;
  assign v_flag    = v_q;

  always_comb begin
    cmd_d       = '0;
    cmd_d.rn    = cmd_rn;
    cmd_d.rm    = cmd_rm;
    cmd_d.rd    = cmd_rd;
    cmd_d.aluop = cmd_aluop;
    cmd_d.shift = cmd_shift;
    cmd_d.asel  = cmd_asel;
    cmd_d.bsel  = cmd_bsel;
    cmd_d.imm   = cmd_imm;
`ifdef DATAPATH_BARREL_EN
    cmd_d.shamt = cmd_shamt;
`endif
    cmd_d.vsel  = cmd_vsel;
    cmd_d.wb    = cmd_wb;
    cmd_d.setf  = cmd_setf;
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE:  state_d = cmd_valid ? S_RDA : S_IDLE;
      S_RDA:   state_d = S_RDB;
      S_RDB:   state_d = S_EXE;
      S_EXE:   state_d = S_WB;
      default: state_d = S_IDLE;
    endcase
  end

  // Decoded read: indices with no backing entry read as zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (cmd_q.rn == RW'(i)) rd_a = rf_q[i];
      if (cmd_q.rm == RW'(i)) rd_b = rf_q[i];
    end
  end

`ifdef DATAPATH_BARREL_EN
  assign shamt = cmd_q.shamt;
`else
  assign shamt = SW'(1);
`endif

  always_comb begin
    sh_b = b_q;
    case (cmd_q.shift)
      2'b01:   sh_b = b_q << shamt;
      2'b10:   sh_b = b_q >> shamt;
      2'b11:   sh_b = $unsigned($signed(b_q) >>> shamt);
      default: sh_b = b_q;
    endcase
  end

  assign a_op = cmd_q.asel ? '0 : a_q;
  assign b_op = cmd_q.bsel ? cmd_q.imm : sh_b;

  always_comb begin
    alu   = a_op + b_op;
    alu_v = 1'b0;
    case (cmd_q.aluop)
      2'b00: begin
        alu   = a_op + b_op;
        alu_v = (a_op[WIDTH-1] == b_op[WIDTH-1]) && (alu[WIDTH-1] != a_op[WIDTH-1]);
      end
      2'b01: begin
        alu   = a_op - b_op;
        alu_v = (a_op[WIDTH-1] != b_op[WIDTH-1]) && (alu[WIDTH-1] != a_op[WIDTH-1]);
      end
      2'b10:   alu = a_op & b_op;
      default: alu = ~b_op;
    endcase
  end

  always_comb begin
    case (cmd_q.vsel)
      2'b00:   wb_data = c_q;
      2'b01:   wb_data = cmd_q.imm;
      2'b10:   wb_data = WIDTH'(pc);
      default: wb_data = mdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cmd_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && cmd_valid) cmd_q <= cmd_d;
      if (state_q == S_RDA) a_q <= rd_a;
      if (state_q == S_RDB) b_q <= rd_b;
      if (state_q == S_EXE) begin
        c_q <= alu;
        if (cmd_q.setf) begin
          z_q <= (alu == '0);
          n_q <= alu[WIDTH-1];
          v_q <= alu_v;
        end
      end
    end
  end

  // Out-of-range destinations match no entry, so the write is dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_q <= '0;
    end else if (state_q == S_WB && cmd_q.wb) begin
      for (int i = 0; i < NREGS; i++)
        if (cmd_q.rd == RW'(i)) rf_q[i] <= wb_data;
    end
  end

endmodule

// File: tb/tb_param_exec_datapath.sv
// Scoreboard bench for param_exec_datapath: directed commands push expected C/flags/done cycle,
// a forked monitor pops and compares on every done pulse.
module tb_param_exec_datapath;

  logic        clk, reset;
  logic        cmd_valid, cmd_ready;
  logic [2:0]  cmd_rn, cmd_rm, cmd_rd;
  logic [1:0]  cmd_aluop, cmd_shift, cmd_vsel;
  logic        cmd_asel, cmd_bsel, cmd_wb, cmd_setf;
  logic [15:0] cmd_imm, mdata, c_out;
`ifdef DATAPATH_BARREL_EN
  logic [3:0]  cmd_shamt;
`endif
  logic [7:0]  pc;
  logic        done, z_flag, n_flag, v_flag;

  typedef struct {
    logic [15:0] c;
    bit          cf;
    logic [2:0]  znv;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  param_exec_datapath #(.WIDTH(16), .NREGS(8), .PC_W(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rn(cmd_rn), .cmd_rm(cmd_rm), .cmd_rd(cmd_rd), .cmd_aluop(cmd_aluop),
    .cmd_shift(cmd_shift), .cmd_asel(cmd_asel), .cmd_bsel(cmd_bsel), .cmd_imm(cmd_imm),
`ifdef DATAPATH_BARREL_EN
    .cmd_shamt(cmd_shamt),
`endif
    .cmd_vsel(cmd_vsel), .cmd_wb(cmd_wb), .cmd_setf(cmd_setf), .mdata(mdata), .pc(pc),
    .done(done), .c_out(c_out), .z_flag(z_flag), .n_flag(n_flag), .v_flag(v_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("c_out", 32'(c_out), 32'(e.c));
          check("done_cycle", 32'(cyc), 32'(e.cyc));
          if (e.cf) check("flags_znv", {29'd0, z_flag, n_flag, v_flag}, {29'd0, e.znv});
        end
      end
    end
  endtask

  task automatic issue(input logic [2:0] rn, rm, rd, input logic [1:0] aluop, shift,
                       input logic asel, bsel, input logic [15:0] imm, input logic [1:0] vsel,
                       input logic wb, setf, input logic [3:0] shamt, input bit push,
                       input logic [15:0] ec, input bit cf, input logic [2:0] znv,
                       input bit hold);
    int n;
    exp_t e;
    @(negedge clk);
    cmd_rn = rn; cmd_rm = rm; cmd_rd = rd; cmd_aluop = aluop; cmd_shift = shift;
    cmd_asel = asel; cmd_bsel = bsel; cmd_imm = imm; cmd_vsel = vsel;
    cmd_wb = wb; cmd_setf = setf;
`ifdef DATAPATH_BARREL_EN
    cmd_shamt = shamt;
`endif
    cmd_valid = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      check("accept_timeout", 32'd0, 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    if (push) begin
      e.c = ec; e.cf = cf; e.znv = znv; e.cyc = cyc + 4;
      sb.push_back(e);
    end
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
  endtask

  task automatic wr_imm(input logic [2:0] rd, input logic [15:0] v);
    issue(0, 0, rd, 2'b00, 2'b00, 1, 1, v, 2'b01, 1, 0, 0, 1, v, 0, 3'b000, 0);
  endtask

  task automatic rd_reg(input logic [2:0] r, input logic [15:0] v);
    issue(0, r, 0, 2'b00, 2'b00, 1, 0, 16'h0, 2'b00, 0, 0, 0, 1, v, 0, 3'b000, 0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0;
    cmd_rn = 0; cmd_rm = 0; cmd_rd = 0; cmd_aluop = 0; cmd_shift = 0;
    cmd_asel = 0; cmd_bsel = 0; cmd_imm = 0; cmd_vsel = 0; cmd_wb = 0; cmd_setf = 0;
`ifdef DATAPATH_BARREL_EN
    cmd_shamt = 0;
`endif
    mdata = 16'h3C3C; pc = 8'hA5;
    fork monitor(); join_none
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_c", 32'(c_out), 32'd0);
    check("rst_flags", {29'd0, z_flag, n_flag, v_flag}, 32'd0);

    // ADD with LSL1 on B
    wr_imm(0, 16'h0007);
    wr_imm(1, 16'h0002);
    issue(0, 1, 2, 2'b00, 2'b01, 0, 0, 16'h0, 2'b00, 1, 1, 0, 1, 16'h000B, 1, 3'b000, 0);
    rd_reg(2, 16'h000B);

    // SUB to zero sets Z; AND without setf leaves flags
    issue(0, 0, 0, 2'b01, 2'b00, 0, 0, 16'h0, 2'b00, 0, 1, 0, 1, 16'h0000, 1, 3'b100, 0);
    issue(0, 1, 0, 2'b10, 2'b00, 0, 0, 16'h0, 2'b00, 0, 0, 0, 1, 16'h0002, 1, 3'b100, 0);

    // Overflow, shifts, NOT, immediate bypasses the shifter
    wr_imm(3, 16'h7FFF);
    wr_imm(4, 16'h0001);
    issue(3, 4, 5, 2'b00, 2'b00, 0, 0, 16'h0, 2'b00, 1, 1, 0, 1, 16'h8000, 1, 3'b011, 0);
    issue(0, 5, 0, 2'b00, 2'b11, 1, 0, 16'h0, 2'b00, 0, 0, 0, 1, 16'hC000, 1, 3'b011, 0);
    issue(5, 4, 0, 2'b01, 2'b00, 0, 0, 16'h0, 2'b00, 0, 1, 0, 1, 16'h7FFF, 1, 3'b001, 0);
    issue(0, 4, 0, 2'b11, 2'b00, 0, 0, 16'h0, 2'b00, 0, 1, 0, 1, 16'hFFFE, 1, 3'b010, 0);
    issue(0, 5, 0, 2'b00, 2'b10, 1, 0, 16'h0, 2'b00, 0, 1, 0, 1, 16'h4000, 1, 3'b000, 0);
    issue(0, 5, 0, 2'b00, 2'b01, 0, 1, 16'h0003, 2'b00, 0, 0, 0, 1, 16'h000A, 1, 3'b000, 0);

    // valid held while busy with changing fields: only the first command lands
    issue(0, 0, 6, 2'b00, 2'b00, 1, 1, 16'h0055, 2'b01, 1, 0, 0, 1, 16'h0055, 0, 3'b000, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("busy_ready", 32'(cmd_ready), 32'd0);
      cmd_imm = 16'h00FF; cmd_rd = 3'd7;
      if (i == 3) cmd_valid = 1'b0;
    end
    rd_reg(6, 16'h0055);
    rd_reg(7, 16'h0000);

    // pc and mdata writeback, rd aliasing a source
    issue(0, 0, 2, 2'b00, 2'b00, 1, 1, 16'h0, 2'b10, 1, 0, 0, 1, 16'h0000, 0, 3'b000, 0);
    rd_reg(2, 16'h00A5);
    issue(0, 0, 3, 2'b00, 2'b00, 1, 1, 16'h0, 2'b11, 1, 0, 0, 1, 16'h0000, 0, 3'b000, 0);
    rd_reg(3, 16'h3C3C);
    issue(1, 1, 1, 2'b00, 2'b00, 0, 0, 16'h0, 2'b00, 1, 0, 0, 1, 16'h0004, 0, 3'b000, 0);
    rd_reg(1, 16'h0004);
`ifdef DATAPATH_BARREL_EN
    issue(0, 4, 0, 2'b00, 2'b01, 1, 0, 16'h0, 2'b00, 0, 0, 4, 1, 16'h0010, 0, 3'b000, 0);
    issue(0, 4, 0, 2'b00, 2'b01, 1, 0, 16'h0, 2'b00, 0, 0, 0, 1, 16'h0001, 0, 3'b000, 0);
`endif

    // Reset during EXE aborts the write and the done pulse
    issue(0, 0, 7, 2'b00, 2'b00, 1, 1, 16'h1234, 2'b01, 1, 1, 0, 0, 16'h0, 0, 3'b000, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", 32'(cmd_ready), 32'd1);
    check("abort_c", 32'(c_out), 32'd0);
    check("abort_flags", {29'd0, z_flag, n_flag, v_flag}, 32'd0);
    for (int r = 0; r < 8; r++) rd_reg(3'(r), 16'h0000);

    repeat (10) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
